// File: rtl/regmem_pkg.sv
// Shared types and constants for the register/RAM datapath sequencer.
package regmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2
    } state_t;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    // RE hold time is counted in a 3-bit counter
    localparam int LOAD_HOLD_MAX = 7;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input arbiter with one-hot grant. Define ARB_RR_EN for round-robin;
// otherwise requester 0 has fixed priority and no pointer state exists.
module rr_arbiter2
    import regmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

`ifdef ARB_RR_EN
    // Index of the requester granted last; starts at 1 so requester 0 wins the first tie.
    logic last_reg;

    always_comb begin
        grant = 2'b00;
        if (req[0] && (!req[1] || last_reg))
            grant = 2'b01;
        else if (req[1])
            grant = 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_reg <= 1'b1;
        else if (en && (|req))
            last_reg <= grant[1];
    end
`else
    always_comb begin
        grant = 2'b00;
        if (req[0])
            grant = 2'b01;
        else if (req[1])
            grant = 2'b10;
    end

    logic unused_rr;
    assign unused_rr = &{1'b0, clk, rst_n, en};
`endif

endmodule

// File: rtl/regmem_sequencer.sv
// Sequences Sel/RE/WE/Addr of the two-register/RAM datapath for two requesters.
// Arbitration policy is selected by the ARB_RR_EN macro (see rr_arbiter2).
module regmem_sequencer
    import regmem_pkg::*;
#(
    parameter int AW        = 2,
    parameter int LOAD_HOLD = 2
) (
    input  logic          CLK,
    input  logic          Rst,
    input  logic          r0_req,
    input  logic          r0_op,
    input  logic          r0_sel,
    input  logic [AW-1:0] r0_addr,
    output logic          r0_ack,
    input  logic          r1_req,
    input  logic          r1_op,
    input  logic          r1_sel,
    input  logic [AW-1:0] r1_addr,
    output logic          r1_ack,
    output logic          Sel,
    output logic          RE,
    output logic          WE,
    output logic [AW-1:0] Addr,
    output logic          busy
);

    localparam int HOLD_C = (LOAD_HOLD > LOAD_HOLD_MAX) ? LOAD_HOLD_MAX :
                            ((LOAD_HOLD < 1) ? 1 : LOAD_HOLD);
    localparam logic [2:0] HOLD = 3'(HOLD_C);

    state_t        state_reg;
    logic [2:0]    cnt_reg;
    logic          who_reg;
    logic [1:0]    grant;
    logic          win_op;
    logic          win_sel;
    logic [AW-1:0] win_addr;
    logic [2:0]    cnt_inc;
    logic          load_last;
    logic          first_ack;

    rr_arbiter2 u_arb (
        .clk   (CLK),
        .rst_n (Rst),
        .req   ({r1_req, r0_req}),
        .en    (state_reg == ST_IDLE),
        .grant (grant)
    );

    always_comb begin
        win_op   = grant[1] ? r1_op   : r0_op;
        win_sel  = grant[1] ? r1_sel  : r0_sel;
        win_addr = grant[1] ? r1_addr : r0_addr;
        cnt_inc  = cnt_reg + 3'd1;
        // Next LOAD cycle is the last one, so ack must be registered now
        load_last = (cnt_inc == HOLD);
        // Ack in the first command cycle: always for a store, for a load only when the hold is one cycle
        first_ack = (win_op == OP_STORE) || (HOLD == 3'd1);
    end

    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 3'd0;
            who_reg   <= 1'b0;
            Sel       <= 1'b0;
            RE        <= 1'b0;
            WE        <= 1'b0;
            Addr      <= '0;
            busy      <= 1'b0;
            r0_ack    <= 1'b0;
            r1_ack    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|grant) begin
                        who_reg <= grant[1];
                        Sel     <= win_sel;
                        Addr    <= win_addr;
                        busy    <= 1'b1;
                        r0_ack  <= grant[0] & first_ack;
                        r1_ack  <= grant[1] & first_ack;
                        if (win_op == OP_STORE) begin
                            state_reg <= ST_STORE;
                            WE        <= 1'b1;
                        end else begin
                            state_reg <= ST_LOAD;
                            RE        <= 1'b1;
                            cnt_reg   <= 3'd1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (cnt_reg == HOLD) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= 3'd0;
                        RE        <= 1'b0;
                        busy      <= 1'b0;
                        r0_ack    <= 1'b0;
                        r1_ack    <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_inc;
                        r0_ack  <= ~who_reg & load_last;
                        r1_ack  <= who_reg & load_last;
                    end
                end
                ST_STORE: begin
                    state_reg <= ST_IDLE;
                    WE        <= 1'b0;
                    busy      <= 1'b0;
                    r0_ack    <= 1'b0;
                    r1_ack    <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= 3'd0;
                    RE        <= 1'b0;
                    WE        <= 1'b0;
                    busy      <= 1'b0;
                    r0_ack    <= 1'b0;
                    r1_ack    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regmem_sequencer.sv
// Self-checking bench for regmem_sequencer: directed vector table, ack scoreboard,
// and hand-written corner sequences. Honors ARB_RR_EN for the contention test.
`timescale 1ns/1ps
module tb_regmem_sequencer;
    import regmem_pkg::*;

    localparam int AW = 2;
    localparam int LH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_req, r0_op, r0_sel, r0_ack;
    logic [AW-1:0] r0_addr;
    logic          r1_req, r1_op, r1_sel, r1_ack;
    logic [AW-1:0] r1_addr;
    logic          Sel, RE, WE, busy;
    logic [AW-1:0] Addr;

    always #5 clk = ~clk;

    regmem_sequencer #(.AW(AW), .LOAD_HOLD(LH)) dut (
        .CLK     (clk),
        .Rst     (rst_n),
        .r0_req  (r0_req),
        .r0_op   (r0_op),
        .r0_sel  (r0_sel),
        .r0_addr (r0_addr),
        .r0_ack  (r0_ack),
        .r1_req  (r1_req),
        .r1_op   (r1_op),
        .r1_sel  (r1_sel),
        .r1_addr (r1_addr),
        .r1_ack  (r1_ack),
        .Sel     (Sel),
        .RE      (RE),
        .WE      (WE),
        .Addr    (Addr),
        .busy    (busy)
    );

    typedef struct {
        bit          who;
        bit          op;
        bit          sel;
        logic [AW-1:0] addr;
    } txn_t;

    typedef struct {
        string         tag;
        bit            who;
        bit            op;
        bit            sel;
        logic [AW-1:0] addr;
        int            exp_cycles;
    } vec_t;

    txn_t sb[$];
    int   checks = 0;
    int   passes = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    // Scoreboard: every ack must match the oldest outstanding expected command.
    always @(negedge clk) begin
        txn_t e;
        if (RE || WE)
            check("re_we_exclusive", 32'(RE & WE), 32'd0);
        if (r0_ack || r1_ack) begin
            check("single_ack", 32'(r0_ack & r1_ack), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'({r1_ack, r0_ack}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_who", 32'(r1_ack), 32'(e.who));
                check("sb_op", 32'(WE), 32'(e.op));
                check("sb_sel", 32'(Sel), 32'(e.sel));
                check("sb_addr", 32'(Addr), 32'(e.addr));
                $display("txn r%0d %s sel=%0d addr=%0d done at %0t",
                         e.who, e.op ? "store" : "load", Sel, Addr, $time);
            end
        end
    end

    task automatic drive(input bit who, input bit req, input bit op, input bit sel,
                         input logic [AW-1:0] addr);
        if (!who) begin
            r0_req = req; r0_op = op; r0_sel = sel; r0_addr = addr;
        end else begin
            r1_req = req; r1_op = op; r1_sel = sel; r1_addr = addr;
        end
    endtask

    function automatic txn_t mk(input bit who, input bit op, input bit sel, input logic [AW-1:0] addr);
        txn_t t;
        t.who = who; t.op = op; t.sel = sel; t.addr = addr;
        return t;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the bubble cycle.
    task automatic do_cmd(input string tag, input bit who, input bit op, input bit sel,
                          input logic [AW-1:0] addr, input int exp_cycles);
        logic ack_w, ack_o;
        sb.push_back(mk(who, op, sel, addr));
        drive(who, 1'b1, op, sel, addr);
        for (int c = 1; c <= exp_cycles; c++) begin
            @(negedge clk);
            ack_w = who ? r1_ack : r0_ack;
            ack_o = who ? r0_ack : r1_ack;
            check({tag, "_re"}, 32'(RE), 32'(op == OP_LOAD));
            check({tag, "_we"}, 32'(WE), 32'(op == OP_STORE));
            check({tag, "_sel"}, 32'(Sel), 32'(sel));
            check({tag, "_addr"}, 32'(Addr), 32'(addr));
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_ack"}, 32'(ack_w), 32'(c == exp_cycles));
            check({tag, "_other_ack"}, 32'(ack_o), 32'd0);
        end
        drive(who, 1'b0, op, sel, addr);
        @(negedge clk);
        check({tag, "_bubble_busy"}, 32'(busy), 32'd0);
        check({tag, "_bubble_re"}, 32'(RE), 32'd0);
        check({tag, "_bubble_we"}, 32'(WE), 32'd0);
        check({tag, "_bubble_addr_hold"}, 32'(Addr), 32'(addr));
    endtask

    vec_t vecs[6];
    int   budget;

    initial begin
        vecs[0] = '{"ld_r0_s1_a2", 1'b0, OP_LOAD,  1'b1, 2'd2, LH};
        vecs[1] = '{"st_r1_s0_a3", 1'b1, OP_STORE, 1'b0, 2'd3, 1};
        vecs[2] = '{"ld_r1_s0_a1", 1'b1, OP_LOAD,  1'b0, 2'd1, LH};
        vecs[3] = '{"st_r0_s1_a0", 1'b0, OP_STORE, 1'b1, 2'd0, 1};
        vecs[4] = '{"ld_r0_s0_a3", 1'b0, OP_LOAD,  1'b0, 2'd3, LH};
        vecs[5] = '{"st_r1_s1_a2", 1'b1, OP_STORE, 1'b1, 2'd2, 1};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({Sel, RE, WE, Addr, busy, r0_ack, r1_ack}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'({Sel, RE, WE, Addr, busy, r0_ack, r1_ack}), 32'd0);

        foreach (vecs[i])
            do_cmd(vecs[i].tag, vecs[i].who, vecs[i].op, vecs[i].sel, vecs[i].addr, vecs[i].exp_cycles);

        // Address changed after grant must not affect the in-flight command.
        sb.push_back(mk(1'b0, OP_LOAD, 1'b0, 2'd1));
        drive(1'b0, 1'b1, OP_LOAD, 1'b0, 2'd1);
        @(negedge clk);
        check("chg_addr_c1", 32'(Addr), 32'd1);
        r0_addr = 2'd3;
        for (int c = 2; c <= LH; c++) begin
            @(negedge clk);
            check("chg_addr_hold", 32'(Addr), 32'd1);
            check("chg_re", 32'(RE), 32'd1);
        end
        check("chg_ack", 32'(r0_ack), 32'd1);
        r0_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("chg_no_rereq_addr", 32'(Addr), 32'd1);
            check("chg_no_rereq_busy", 32'(busy), 32'd0);
        end
        do_cmd("chg_rereq_a3", 1'b0, OP_LOAD, 1'b0, 2'd3, LH);

        // Reset asserted in the second cycle of a load.
        sb.push_back(mk(1'b0, OP_LOAD, 1'b1, 2'd2));
        drive(1'b0, 1'b1, OP_LOAD, 1'b1, 2'd2);
        @(negedge clk);
        check("mid_rst_re_c1", 32'(RE), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_async", 32'({Sel, RE, WE, Addr, busy, r0_ack, r1_ack}), 32'd0);
        check("mid_rst_no_ack", 32'(sb.size()), 32'd1);
        sb.delete();
        drive(1'b0, 1'b0, OP_LOAD, 1'b1, 2'd2);
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_hold_ack", 32'(r0_ack), 32'd0);
            check("mid_rst_hold_busy", 32'(busy), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        do_cmd("post_rst_store", 1'b0, OP_STORE, 1'b1, 2'd2, 1);

        // A short r0 pulse while r1's store is in flight is withdrawn before any IDLE sample.
        sb.push_back(mk(1'b1, OP_STORE, 1'b0, 2'd3));
        drive(1'b1, 1'b1, OP_STORE, 1'b0, 2'd3);
        @(negedge clk);
        check("pulse_we", 32'(WE), 32'd1);
        check("pulse_r1_ack", 32'(r1_ack), 32'd1);
        drive(1'b1, 1'b0, OP_STORE, 1'b0, 2'd3);
        drive(1'b0, 1'b1, OP_LOAD, 1'b0, 2'd0);
        @(negedge clk);
        r0_req = 1'b0;
        check("pulse_bubble_busy", 32'(busy), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("pulse_no_r0_ack", 32'(r0_ack), 32'd0);
            check("pulse_no_grant", 32'(busy), 32'd0);
        end

        // Continuous contention after a fresh reset (pointer back to its reset value).
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
`ifdef ARB_RR_EN
            if (k % 2 == 0)
                sb.push_back(mk(1'b0, OP_STORE, 1'b0, 2'd0));
            else
                sb.push_back(mk(1'b1, OP_STORE, 1'b1, 2'd1));
`else
            sb.push_back(mk(1'b0, OP_STORE, 1'b0, 2'd0));
`endif
        end
        drive(1'b0, 1'b1, OP_STORE, 1'b0, 2'd0);
        drive(1'b1, 1'b1, OP_STORE, 1'b1, 2'd1);
        budget = 60;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
        check("contention_all_granted", 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            check("contention_quiet", 32'({r1_ack, r0_ack}), 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
